// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - two-requester round-robin front end for a shared combinational ALU
module alu_share_arb #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [4:0]       req0_aluOp,
  input  logic [1:0]       req0_last2Bits,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  output logic             req0_gnt,
  input  logic             req1_valid,
  input  logic [4:0]       req1_aluOp,
  input  logic [1:0]       req1_last2Bits,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  output logic             req1_gnt,
  output logic [4:0]       alu_aluOp,
  output logic [1:0]       alu_last2Bits,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_err,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  input  logic             resp_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q;
  logic [4:0]       op_q, op_d;
  logic [1:0]       l2_q, l2_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q;
  logic [WIDTH-1:0] resp_data_q;
  logic             resp_err_q;
  logic             grant_any;
  logic             grant_sel;

  // Arbitration: a lone requester always wins, contention is settled by the pointer
  always_comb begin
    grant_any = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
    grant_sel = (req0_valid && req1_valid) ? ptr_q : req1_valid;
    op_d      = grant_sel ? req1_aluOp     : req0_aluOp;
    l2_d      = grant_sel ? req1_last2Bits : req0_last2Bits;
    a_d       = grant_sel ? req1_A         : req0_A;
    b_d       = grant_sel ? req1_B         : req0_B;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: EXEC always lasts exactly one cycle, RESP waits for the consumer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; grants are suppressed while reset is held
  always_comb begin
    req0_gnt   = grant_any && !grant_sel;
    req1_gnt   = grant_any && grant_sel;
    busy       = (state_q != IDLE);
    resp_valid = (state_q == RESP);
  end

  // Latch the granted operation and hand priority to the other requester
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
      op_q  <= '0;
      l2_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      id_q  <= 1'b0;
    end else if (grant_any) begin
      ptr_q <= ~grant_sel;
      op_q  <= op_d;
      l2_q  <= l2_d;
      a_q   <= a_d;
      b_q   <= b_d;
      id_q  <= grant_sel;
    end
  end

  // Capture the ALU result at the end of EXEC; held untouched through RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else if (state_q == EXEC) begin
      resp_data_q <= alu_out;
      resp_err_q  <= alu_err;
    end
  end

  assign alu_aluOp     = op_q;
  assign alu_last2Bits = l2_q;
  assign alu_A         = a_q;
  assign alu_B         = b_q;
  assign resp_id       = id_q;
  assign resp_data     = resp_data_q;
  assign resp_err      = resp_err_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed bench for alu_share_arb with a stub ALU
module tb_alu_share_arb;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic [4:0]       req0_aluOp, req1_aluOp;
  logic [1:0]       req0_last2Bits, req1_last2Bits;
  logic [WIDTH-1:0] req0_A, req0_B, req1_A, req1_B;
  logic             req0_gnt, req1_gnt;
  logic [4:0]       alu_aluOp;
  logic [1:0]       alu_last2Bits;
  logic [WIDTH-1:0] alu_A, alu_B, alu_out;
  logic             alu_err;
  logic             resp_valid, resp_id, resp_err, resp_ready, busy;
  logic [WIDTH-1:0] resp_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        id;
    logic [4:0]  op;
    logic [1:0]  l2;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  alu_share_arb #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_aluOp(req0_aluOp), .req0_last2Bits(req0_last2Bits),
    .req0_A(req0_A), .req0_B(req0_B), .req0_gnt(req0_gnt),
    .req1_valid(req1_valid), .req1_aluOp(req1_aluOp), .req1_last2Bits(req1_last2Bits),
    .req1_A(req1_A), .req1_B(req1_B), .req1_gnt(req1_gnt),
    .alu_aluOp(alu_aluOp), .alu_last2Bits(alu_last2Bits), .alu_A(alu_A), .alu_B(alu_B),
    .alu_out(alu_out), .alu_err(alu_err),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
    .resp_ready(resp_ready), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stub ALU: 01000 addi, 00001 R-type (add/sub/and/xor), anything else illegal
  always_comb begin
    alu_out = '0;
    alu_err = 1'b0;
    case (alu_aluOp)
      5'b01000: alu_out = alu_A + alu_B;
      5'b00001: begin
        case (alu_last2Bits)
          2'd0:    alu_out = alu_A + alu_B;
          2'd1:    alu_out = alu_A - alu_B;
          2'd2:    alu_out = alu_A & alu_B;
          default: alu_out = alu_A ^ alu_B;
        endcase
      end
      default: alu_err = 1'b1;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic [4:0] op, input logic [1:0] l2,
                       input logic [15:0] a, input logic [15:0] b);
    if (id) begin
      req1_valid = 1'b1; req1_aluOp = op; req1_last2Bits = l2; req1_A = a; req1_B = b;
    end else begin
      req0_valid = 1'b1; req0_aluOp = op; req0_last2Bits = l2; req0_A = a; req0_B = b;
    end
  endtask

  int   g_cnt;
  int   g_cyc[8];
  logic g_id[8];
  logic [15:0] held;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 5'b01000, 2'd0, 16'h0005, 16'h0003, 16'h0008, 1'b0};
    vecs[1] = '{1'b1, 5'b00001, 2'd1, 16'h0010, 16'h0001, 16'h000F, 1'b0};
    vecs[2] = '{1'b0, 5'b00001, 2'd2, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0};
    vecs[3] = '{1'b1, 5'b00001, 2'd3, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0};
    vecs[4] = '{1'b0, 5'b00110, 2'd0, 16'h1111, 16'h2222, 16'h0000, 1'b1};
    vecs[5] = '{1'b1, 5'b01000, 2'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0};

    rst = 1'b1; resp_ready = 1'b1;
    req0_valid = 0; req0_aluOp = 0; req0_last2Bits = 0; req0_A = 0; req0_B = 0;
    req1_valid = 0; req1_aluOp = 0; req1_last2Bits = 0; req1_A = 0; req1_B = 0;
    tick(); tick();

    // Reset state, including a request held during reset
    req0_valid = 1'b1;
    #1;
    chk("rst_gnt0", 32'(req0_gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_data", 32'(resp_data), 0);
    chk("rst_alu_A", 32'(alu_A), 0);
    req0_valid = 1'b0;
    tick();
    rst = 1'b0;

    // Single-request table: grant in N, EXEC in N+1, response in N+2
    foreach (vecs[i]) begin
      tick();
      drive(vecs[i].id, vecs[i].op, vecs[i].l2, vecs[i].a, vecs[i].b);
      @(negedge clk);
      chk($sformatf("v%0d_gnt0", i), 32'(req0_gnt), 32'(!vecs[i].id));
      chk($sformatf("v%0d_gnt1", i), 32'(req1_gnt), 32'(vecs[i].id));
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_exec_busy", i), 32'(busy), 1);
      chk($sformatf("v%0d_exec_rv", i), 32'(resp_valid), 0);
      chk($sformatf("v%0d_alu_op", i), 32'(alu_aluOp), 32'(vecs[i].op));
      chk($sformatf("v%0d_alu_A", i), 32'(alu_A), 32'(vecs[i].a));
      tick();
      @(negedge clk);
      chk($sformatf("v%0d_rv", i), 32'(resp_valid), 1);
      chk($sformatf("v%0d_id", i), 32'(resp_id), 32'(vecs[i].id));
      chk($sformatf("v%0d_data", i), 32'(resp_data), 32'(vecs[i].exp_data));
      chk($sformatf("v%0d_err", i), 32'(resp_err), 32'(vecs[i].exp_err));
    end

    // Contention from reset: grants alternate 0,1,0,1 three cycles apart
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 5'b01000, 2'd0, 16'h0001, 16'h0001);
    drive(1'b1, 5'b01000, 2'd0, 16'h0002, 16'h0002);
    g_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req0_gnt && req1_gnt) chk("both_gnt", 32'(req0_gnt && req1_gnt), 0);
      if ((req0_gnt || req1_gnt) && g_cnt < 8) begin
        g_cyc[g_cnt] = c;
        g_id[g_cnt]  = req1_gnt;
        g_cnt++;
      end
    end
    chk("cont_count", 32'(g_cnt), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < g_cnt) begin
        chk($sformatf("cont_id%0d", k), 32'(g_id[k]), 32'(k % 2));
        chk($sformatf("cont_cyc%0d", k), 32'(g_cyc[k]), 32'(3 * k));
      end
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure: result held five cycles, late request waits ungranted
    resp_ready = 1'b0;
    drive(1'b0, 5'b01000, 2'd0, 16'h1234, 16'h0001);
    @(negedge clk);
    chk("bp_gnt0", 32'(req0_gnt), 1);
    tick();
    req0_valid = 1'b0;
    drive(1'b1, 5'b00001, 2'd0, 16'h0002, 16'h0002);
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_rv%0d", k), 32'(resp_valid), 1);
      chk($sformatf("bp_data%0d", k), 32'(resp_data), 32'h1235);
      chk($sformatf("bp_id%0d", k), 32'(resp_id), 0);
      chk($sformatf("bp_nognt%0d", k), 32'(req0_gnt || req1_gnt), 0);
      chk($sformatf("bp_busy%0d", k), 32'(busy), 1);
      tick();
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rv_last", 32'(resp_valid), 1);
    tick();
    @(negedge clk);
    chk("bp_idle_busy", 32'(busy), 0);
    chk("bp_waiter_gnt1", 32'(req1_gnt), 1);
    tick();
    req1_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("bp2_rv", 32'(resp_valid), 1);
    chk("bp2_id", 32'(resp_id), 1);
    chk("bp2_data", 32'(resp_data), 32'h0004);
    tick();

    // Reset during EXEC discards the operation and clears the pointer
    drive(1'b0, 5'b01000, 2'd0, 16'h0007, 16'h0001);
    @(negedge clk);
    chk("mr_gnt0", 32'(req0_gnt), 1);
    tick();
    @(negedge clk);
    chk("mr_exec_busy", 32'(busy), 1);
    #1 rst = 1'b1;
    #1;
    chk("mr_busy", 32'(busy), 0);
    chk("mr_rv", 32'(resp_valid), 0);
    chk("mr_gnt0_rst", 32'(req0_gnt), 0);
    chk("mr_alu_A", 32'(alu_A), 0);
    chk("mr_data", 32'(resp_data), 0);
    tick();
    rst = 1'b0;
    req0_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("mr_norv%0d", k), 32'(resp_valid), 0);
    end
    tick();
    drive(1'b0, 5'b01000, 2'd0, 16'h0001, 16'h0000);
    drive(1'b1, 5'b01000, 2'd0, 16'h0002, 16'h0000);
    @(negedge clk);
    chk("mr_ptr_gnt0", 32'(req0_gnt), 1);
    chk("mr_ptr_gnt1", 32'(req1_gnt), 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
